// File: rtl/out_writeback_pkg.sv
// Shared types and width helpers for the output write-back stage.
package out_writeback_pkg;

  localparam int LANE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wb_state_e;

  function automatic int word_width(input int lanes);
    return lanes * LANE_W;
  endfunction

  // Pooled rows carry half the lanes; two of them make one full word.
  function automatic int half_width(input int lanes);
    return (lanes / 2) * LANE_W;
  endfunction

endpackage

// File: rtl/out_writeback_fifo.sv
// Small synchronous FIFO; head is presented straight from storage, gated to zero when empty.
module wb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/out_writeback.sv
// Collects post-processed or pooled rows, packs pooled halves into full words,
// and writes them to consecutive output-buffer addresses under backpressure.
module out_writeback
  import out_writeback_pkg::*;
#(
  parameter int POX        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic                      cfg_pool_en,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [ADDR_W-1:0]         cfg_word_cnt,
  input  logic [POX*LANE_W-1:0]     post_out,
  input  logic                      post_out_valid,
  input  logic [POX/2*LANE_W-1:0]   pooling_out,
  input  logic                      pooling_out_valid,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [POX*LANE_W-1:0]     wr_data,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int WORD_W = word_width(POX);
  localparam int HALF_W = half_width(POX);

  wb_state_e         state_q, state_d;
  logic              pool_en_q, pool_en_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] push_cnt_q, push_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              half_q, half_d;
  logic [HALF_W-1:0] pack_lo_q, pack_lo_d;
  logic              overflow_q, overflow_d;

  logic              push_req;
  logic [WORD_W-1:0] push_word;
  logic [ADDR_W-1:0] push_cnt_inc;
  logic              fifo_full, fifo_empty, pop;
  logic [WORD_W-1:0] fifo_head;

  wb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_en        = !fifo_empty;
  assign wr_data      = fifo_head;
  assign pop          = wr_en && wr_ready;
  assign wr_addr      = base_addr_q + wr_cnt_q;
  assign overflow     = overflow_q;
  assign push_cnt_inc = push_cnt_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = (cfg_word_cnt == '0) ? DONE : RUN;
      RUN:     if (push_req && (push_cnt_inc == word_cnt_q)) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Dropped words still count toward the tile so the FSM cannot stall on overflow.
  always_comb begin
    pool_en_d   = pool_en_q;
    base_addr_d = base_addr_q;
    word_cnt_d  = word_cnt_q;
    push_cnt_d  = push_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    half_d      = half_q;
    pack_lo_d   = pack_lo_q;
    overflow_d  = overflow_q;
    push_req    = 1'b0;
    push_word   = post_out;

    if (pop) wr_cnt_d = wr_cnt_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          pool_en_d   = cfg_pool_en;
          base_addr_d = cfg_base_addr;
          word_cnt_d  = cfg_word_cnt;
          push_cnt_d  = '0;
          wr_cnt_d    = '0;
          half_d      = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      RUN: begin
        if (pool_en_q) begin
          if (pooling_out_valid) begin
            if (half_q) begin
              push_req  = 1'b1;
              push_word = {pooling_out, pack_lo_q};
              half_d    = 1'b0;
            end else begin
              pack_lo_d = pooling_out;
              half_d    = 1'b1;
            end
          end
        end else begin
          push_req = post_out_valid;
        end
        if (push_req) begin
          push_cnt_d = push_cnt_inc;
          if (fifo_full && !pop) overflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pool_en_q   <= 1'b0;
      base_addr_q <= '0;
      word_cnt_q  <= '0;
      push_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      half_q      <= 1'b0;
      pack_lo_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pool_en_q   <= pool_en_d;
      base_addr_q <= base_addr_d;
      word_cnt_q  <= word_cnt_d;
      push_cnt_q  <= push_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      half_q      <= half_d;
      pack_lo_q   <= pack_lo_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_out_writeback.sv
// Directed bench for out_writeback: a table of whole tiles plus hand-written
// backpressure, zero-count and mid-tile reset sequences.
module tb_out_writeback;

  localparam int POX        = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 12;
  localparam int W          = POX * 16;
  localparam int HW         = POX / 2 * 16;

  typedef struct {
    logic              pool_en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] cnt;
    int                beats;
    logic              noise;
    logic              restart;
    int                exp_writes;
    logic              exp_ovf;
  } tile_vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      data;
  } wr_rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start, cfg_pool_en;
  logic [ADDR_W-1:0] cfg_base_addr, cfg_word_cnt;
  logic [W-1:0]      post_out;
  logic              post_out_valid;
  logic [HW-1:0]     pooling_out;
  logic              pooling_out_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;
  logic              wr_ready;
  logic              busy, done, overflow;

  int      compared   = 0;
  int      mismatched = 0;
  int      done_cnt   = 0;
  wr_rec_t wq[$];

  always #5 clk = ~clk;

  out_writeback #(
    .POX        (POX),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_start         (cfg_start),
    .cfg_pool_en       (cfg_pool_en),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_word_cnt      (cfg_word_cnt),
    .post_out          (post_out),
    .post_out_valid    (post_out_valid),
    .pooling_out       (pooling_out),
    .pooling_out_valid (pooling_out_valid),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow)
  );

  // Record every accepted write and every cycle with done high, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en && wr_ready) wq.push_back('{addr: wr_addr, data: wr_data});
      if (done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] word_pat(input int k);
    logic [W-1:0] w;
    for (int i = 0; i < POX; i++) w[i*16 +: 16] = 16'hA000 + 16'(k * 4 + i);
    return w;
  endfunction

  function automatic logic [HW-1:0] half_pat(input int j);
    logic [HW-1:0] h;
    for (int i = 0; i < POX / 2; i++) h[i*16 +: 16] = 16'hB000 + 16'(j * 2 + i);
    return h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    cfg_start         = 1'b0;
    cfg_pool_en       = 1'b0;
    cfg_base_addr     = '0;
    cfg_word_cnt      = '0;
    post_out          = '0;
    post_out_valid    = 1'b0;
    pooling_out       = '0;
    pooling_out_valid = 1'b0;
  endtask

  task automatic applyStimulus(input tile_vec_t v);
    wq.delete();
    done_cnt      = 0;
    cfg_pool_en   = v.pool_en;
    cfg_base_addr = v.base;
    cfg_word_cnt  = v.cnt;
    cfg_start     = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      if (v.pool_en) begin
        pooling_out       = half_pat(b);
        pooling_out_valid = 1'b1;
        post_out          = word_pat(100 + b);
        post_out_valid    = v.noise;
      end else begin
        post_out          = word_pat(b);
        post_out_valid    = 1'b1;
        pooling_out       = half_pat(50 + b);
        pooling_out_valid = v.noise;
      end
      if (v.restart && b == 1) begin
        cfg_start     = 1'b1;
        cfg_base_addr = v.base + 12'h100;
        cfg_word_cnt  = v.cnt + 12'd5;
      end
      step();
      cfg_start = 1'b0;
    end
    post_out_valid    = 1'b0;
    pooling_out_valid = 1'b0;
    for (int c = 0; c < 300 && done_cnt == 0; c++) step();
    step();
    step();
  endtask

  task automatic checkTile(input int id, input tile_vec_t v);
    logic [W-1:0]      exp_data;
    logic [ADDR_W-1:0] exp_addr;
    checkOutput($sformatf("t%0d write_count", id), W'(wq.size()), W'(v.exp_writes));
    for (int k = 0; k < wq.size() && k < v.exp_writes; k++) begin
      exp_addr = v.base + ADDR_W'(k);
      exp_data = v.pool_en ? {half_pat(2 * k + 1), half_pat(2 * k)} : word_pat(k);
      checkOutput($sformatf("t%0d addr%0d", id, k), W'(wq[k].addr), W'(exp_addr));
      checkOutput($sformatf("t%0d data%0d", id, k), wq[k].data, exp_data);
    end
    checkOutput($sformatf("t%0d done_cycles", id), W'(done_cnt), W'(1));
    checkOutput($sformatf("t%0d busy_after", id), W'(busy), W'(0));
    checkOutput($sformatf("t%0d overflow", id), W'(overflow), W'(v.exp_ovf));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " wr_en"}, W'(wr_en), W'(0));
    checkOutput({tag, " wr_addr"}, W'(wr_addr), W'(0));
    checkOutput({tag, " wr_data"}, wr_data, W'(0));
    checkOutput({tag, " busy"}, W'(busy), W'(0));
    checkOutput({tag, " done"}, W'(done), W'(0));
    checkOutput({tag, " overflow"}, W'(overflow), W'(0));
  endtask

  tile_vec_t vecs[7];
  tile_vec_t fresh;

  initial begin
    //        pool base     cnt    beats noise restart writes ovf
    vecs[0] = '{1'b0, 12'h010, 12'd4, 4, 1'b0, 1'b0, 4, 1'b0};
    vecs[1] = '{1'b1, 12'h100, 12'd2, 4, 1'b0, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b0, 12'hFFE, 12'd3, 3, 1'b0, 1'b0, 3, 1'b0};
    vecs[3] = '{1'b0, 12'h040, 12'd3, 3, 1'b1, 1'b1, 3, 1'b0};
    vecs[4] = '{1'b1, 12'h080, 12'd2, 5, 1'b1, 1'b0, 2, 1'b0};
    vecs[5] = '{1'b0, 12'h200, 12'd2, 4, 1'b0, 1'b0, 2, 1'b0};
    vecs[6] = '{1'b1, 12'h3F0, 12'd3, 6, 1'b0, 1'b1, 3, 1'b0};
    fresh   = '{1'b0, 12'h020, 12'd2, 2, 1'b0, 1'b0, 2, 1'b0};

    idleInputs();
    wr_ready = 1'b1;
    rst      = 1'b0;
    step();
    step();
    checkAllZero("reset");
    rst = 1'b1;
    step();
    checkAllZero("idle");

    for (int t = 0; t < 7; t++) begin
      applyStimulus(vecs[t]);
      checkTile(t, vecs[t]);
    end

    // Backpressure: writes held for 12 cycles while 10 beats arrive.
    wq.delete();
    done_cnt      = 0;
    wr_ready      = 1'b0;
    cfg_pool_en   = 1'b0;
    cfg_base_addr = 12'h300;
    cfg_word_cnt  = 12'd10;
    cfg_start     = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      post_out       = word_pat(b);
      post_out_valid = 1'b1;
      step();
      if (b == 0) begin
        checkOutput("bp first wr_en", W'(wr_en), W'(1));
        checkOutput("bp first data", wr_data, word_pat(0));
        checkOutput("bp first addr", W'(wr_addr), W'(12'h300));
      end
    end
    post_out_valid = 1'b0;
    step();
    checkOutput("bp held wr_en", W'(wr_en), W'(1));
    checkOutput("bp held data", wr_data, word_pat(0));
    checkOutput("bp held addr", W'(wr_addr), W'(12'h300));
    checkOutput("bp overflow", W'(overflow), W'(1));
    checkOutput("bp busy", W'(busy), W'(1));
    wr_ready = 1'b1;
    for (int c = 0; c < 300 && done_cnt == 0; c++) step();
    step();
    checkOutput("bp write_count", W'(wq.size()), W'(8));
    for (int k = 0; k < wq.size() && k < 8; k++) begin
      checkOutput($sformatf("bp addr%0d", k), W'(wq[k].addr), W'(12'h300 + 12'(k)));
      checkOutput($sformatf("bp data%0d", k), wq[k].data, word_pat(k));
    end
    checkOutput("bp done_cycles", W'(done_cnt), W'(1));
    checkOutput("bp overflow sticky", W'(overflow), W'(1));

    // Zero-length tile completes immediately and clears overflow.
    wq.delete();
    done_cnt      = 0;
    cfg_base_addr = 12'h123;
    cfg_word_cnt  = 12'd0;
    cfg_start     = 1'b1;
    step();
    cfg_start = 1'b0;
    checkOutput("zero done", W'(done), W'(1));
    checkOutput("zero busy", W'(busy), W'(1));
    checkOutput("zero overflow cleared", W'(overflow), W'(0));
    step();
    checkOutput("zero done after", W'(done), W'(0));
    checkOutput("zero busy after", W'(busy), W'(0));
    step();
    checkOutput("zero writes", W'(wq.size()), W'(0));
    checkOutput("zero done_cycles", W'(done_cnt), W'(1));

    // Reset during DRAIN with words still queued.
    wr_ready      = 1'b0;
    cfg_base_addr = 12'h050;
    cfg_word_cnt  = 12'd3;
    cfg_start     = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      post_out       = word_pat(b);
      post_out_valid = 1'b1;
      step();
    end
    post_out_valid = 1'b0;
    checkOutput("mid busy", W'(busy), W'(1));
    checkOutput("mid wr_en", W'(wr_en), W'(1));
    wq.delete();
    done_cnt = 0;
    rst      = 1'b0;
    step();
    checkAllZero("mid reset");
    rst      = 1'b1;
    wr_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checkOutput("mid no done", W'(done_cnt), W'(0));
    checkOutput("mid no writes", W'(wq.size()), W'(0));

    applyStimulus(fresh);
    checkTile(99, fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
